// File: rtl/ss_scan_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ss_scan_decoder_pkg
// Shared definitions for the seven-segment scan driver / scan decoder pair:
// active-low segment encodings, anode indices, bit-order constants, the
// decoder FSM state type and small helpers for anode-select qualification.
// ----------------------------------------------------------------------------
package ss_scan_decoder_pkg;

  // Active-low cathode encodings {dp,g,f,e,d,c,b,a}, decimal point off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Anode (digit slot) indices; bit n of the anode bus selects slot n.
  localparam int ANODE_MINS1  = 0;
  localparam int ANODE_MINS2  = 1;
  localparam int ANODE_HOURS1 = 2;
  localparam int ANODE_HOURS2 = 3;
  localparam int NUM_DIGITS   = 4;

  // Bit order of the cathode bus.
  localparam int SEG_A_BIT  = 0;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  // Unused anode bits [7:4] must read high on a legal select.
  localparam logic [3:0] ANODE_UNUSED_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_SETTLE,
    ST_HOLD
  } scan_state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } bcd_t;

  // Legal select: unused bits high and exactly one digit anode driven low.
  function automatic logic select_valid(input logic [7:0] anodes);
    logic [3:0] low;
    low = ~anodes[3:0];
    return (anodes[7:4] == ANODE_UNUSED_IDLE) && ($countones(low) == 1);
  endfunction

  // Slot index of the single low anode; only meaningful when select_valid.
  function automatic logic [1:0] select_index(input logic [3:0] anodes);
    case (anodes)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ss_scan_decoder_seg7_to_bcd.sv
// ----------------------------------------------------------------------------
// seg7_to_bcd
// Combinational decode of an active-low 7-segment pattern {g..a} to BCD.
// Ports:
//   seg  in  7  active-low segments {g,f,e,d,c,b,a}
//   bcd  out 5  {err, digit}; undecodable patterns give err=1, digit=4'hF
// ----------------------------------------------------------------------------
module seg7_to_bcd
  import ss_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output bcd_t       bcd
);

  localparam logic [6:0] CODE_0 = SEG_0[6:0];
  localparam logic [6:0] CODE_1 = SEG_1[6:0];
  localparam logic [6:0] CODE_2 = SEG_2[6:0];
  localparam logic [6:0] CODE_3 = SEG_3[6:0];
  localparam logic [6:0] CODE_4 = SEG_4[6:0];
  localparam logic [6:0] CODE_5 = SEG_5[6:0];
  localparam logic [6:0] CODE_6 = SEG_6[6:0];
  localparam logic [6:0] CODE_7 = SEG_7[6:0];
  localparam logic [6:0] CODE_8 = SEG_8[6:0];
  localparam logic [6:0] CODE_9 = SEG_9[6:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bcd.err   = 1'b0;
    bcd.digit = 4'h0;
    case (seg)
      CODE_0:  bcd.digit = 4'd0;
      CODE_1:  bcd.digit = 4'd1;
      CODE_2:  bcd.digit = 4'd2;
      CODE_3:  bcd.digit = 4'd3;
      CODE_4:  bcd.digit = 4'd4;
      CODE_5:  bcd.digit = 4'd5;
      CODE_6:  bcd.digit = 4'd6;
      CODE_7:  bcd.digit = 4'd7;
      CODE_8:  bcd.digit = 4'd8;
      CODE_9:  bcd.digit = 4'd9;
      default: begin
        bcd.err   = 1'b1;
        bcd.digit = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/ss_scan_decoder.sv
// ----------------------------------------------------------------------------
// ss_scan_decoder
// Samples a multiplexed seven-segment scan bus, waits for each digit to be
// stable, and rebuilds the four displayed BCD digits. A completed frame
// (all four slots seen) is published with a one-cycle FRAME_VALID strobe.
// Ports:
//   CLK100MHZ       in   1  clock, rising edge
//   RESET_N         in   1  async active-low reset
//   SegmentDrivers  in   8  anodes, active-low; [3:0]=hours2,hours1,mins2,mins1
//   SevenSegment    in   8  cathodes, active-low {dp,g,f,e,d,c,b,a}
//   hours2..mins1   out  4  captured digits
//   DP              out  4  captured decimal points, active-high, anode order
//   FRAME_VALID     out  1  one-cycle strobe: outputs updated this cycle
//   SEG_ERR         out  1  last frame held an undecodable pattern
//   STALE           out  1  no frame completed within TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module ss_scan_decoder
  import ss_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2097152
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_N,
  input  logic [7:0] SegmentDrivers,
  input  logic [7:0] SevenSegment,
  output logic [3:0] hours2,
  output logic [3:0] hours1,
  output logic [3:0] mins2,
  output logic [3:0] mins1,
  output logic [3:0] DP,
  output logic       FRAME_VALID,
  output logic       SEG_ERR,
  output logic       STALE
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [15:0] p_in;
  logic [15:0] p_q;
  logic        p_changed;
  logic        sel_ok;
  logic [1:0]  sel_idx;
  bcd_t        decoded;

  scan_state_t state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic          capture;

  logic [NUM_DIGITS-1:0][3:0] slot_digit;
  logic [NUM_DIGITS-1:0]      slot_dp;
  logic [NUM_DIGITS-1:0]      seen_q, seen_d;
  logic                       frame_err_q, frame_err_d;
  logic                       frame_done;
  logic [TW-1:0]              timeout_cnt_q;

  assign p_in      = {SegmentDrivers, SevenSegment};
  assign p_changed = (p_in != p_q);
  assign sel_ok    = select_valid(SegmentDrivers);
  assign sel_idx   = select_index(SegmentDrivers[3:0]);
  assign frame_done = (seen_q == 4'hF);

  seg7_to_bcd u_decode (
    .seg (SevenSegment[SEG_G_BIT:SEG_A_BIT]),
    .bcd (decoded)
  );

  // Settle / hold state machine: a digit is captured once per stable run.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (sel_ok) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end
      ST_SETTLE: begin
        if (p_changed) begin
          state_d      = sel_ok ? ST_SETTLE : ST_BLANK;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (p_changed) begin
          state_d      = sel_ok ? ST_SETTLE : ST_BLANK;
          settle_cnt_d = '0;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Frame completion clears the mask first, so a capture on the same edge
  // is credited to the following frame.
  always_comb begin
    seen_d      = frame_done ? '0 : seen_q;
    frame_err_d = frame_done ? 1'b0 : frame_err_q;
    if (capture) begin
      seen_d[sel_idx] = 1'b1;
      frame_err_d     = frame_err_d | decoded.err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_BLANK;
      settle_cnt_q <= '0;
      p_q          <= 16'hFFFF;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      p_q          <= p_in;
    end
  end

  // NOTE: the digit slots are reset too, so a reset mid-frame discards
  // partial captures instead of leaking stale digits into the next frame.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_digit    <= '0;
      slot_dp       <= '0;
      seen_q        <= '0;
      frame_err_q   <= 1'b0;
      hours2        <= 4'h0;
      hours1        <= 4'h0;
      mins2         <= 4'h0;
      mins1         <= 4'h0;
      DP            <= 4'h0;
      SEG_ERR       <= 1'b0;
      FRAME_VALID   <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      seen_q      <= seen_d;
      frame_err_q <= frame_err_d;
      FRAME_VALID <= frame_done;

      if (capture) begin
        slot_digit[sel_idx] <= decoded.digit;
        slot_dp[sel_idx]    <= ~SevenSegment[SEG_DP_BIT];
      end

      if (frame_done) begin
        hours2  <= slot_digit[ANODE_HOURS2];
        hours1  <= slot_digit[ANODE_HOURS1];
        mins2   <= slot_digit[ANODE_MINS2];
        mins1   <= slot_digit[ANODE_MINS1];
        DP      <= slot_dp;
        SEG_ERR <= frame_err_q;
      end

      // Cleared on the edge that raises FRAME_VALID, so STALE drops with it.
      if (frame_done) begin
        timeout_cnt_q <= '0;
      end else if (timeout_cnt_q != TIMEOUT_MAX) begin
        timeout_cnt_q <= timeout_cnt_q + 1'b1;
      end
    end
  end

  assign STALE = (timeout_cnt_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_ss_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_ss_scan_decoder
// Directed display scenarios plus randomized scan traffic, compared every
// cycle against a run-length reference model of the scan decoder.
// ----------------------------------------------------------------------------
module tb_ss_scan_decoder;

  localparam int TB_SETTLE  = 16;
  localparam int TB_TIMEOUT = 300;

  logic       clk;
  logic       rst_n;
  logic [7:0] seg_drivers;
  logic [7:0] seven_segment;
  logic [3:0] hours2, hours1, mins2, mins1, dp;
  logic       frame_valid, seg_err, stale;

  ss_scan_decoder #(
    .SETTLE_CYCLES  (TB_SETTLE),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .CLK100MHZ      (clk),
    .RESET_N        (rst_n),
    .SegmentDrivers (seg_drivers),
    .SevenSegment   (seven_segment),
    .hours2         (hours2),
    .hours1         (hours1),
    .mins2          (mins2),
    .mins1          (mins1),
    .DP             (dp),
    .FRAME_VALID    (frame_valid),
    .SEG_ERR        (seg_err),
    .STALE          (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] seg_table [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic [3:0]  m_digit [4];
  logic        m_dp    [4];
  logic        m_seen  [4];
  logic        m_ferr;
  logic [3:0]  e_digit [4];
  logic [3:0]  e_dp;
  logic        e_err;
  logic        e_fv;
  int          cycles_since;
  logic [15:0] prev_p;
  int          run_len;

  // Observed frame record for directed checks.
  int         frames;
  logic [15:0] last_digits;
  logic       last_err;
  logic       stale_at_fv;

  function automatic int ref_slot(input logic [7:0] sel);
    int lows = 0;
    int idx  = -1;
    if (sel[7:4] != 4'hF) return -1;
    for (int i = 0; i < 4; i++) begin
      if (!sel[i]) begin
        lows++;
        idx = i;
      end
    end
    return (lows == 1) ? idx : -1;
  endfunction

  function automatic logic [4:0] ref_decode(input logic [6:0] pat);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] code;
      code = seg_table[i];
      if (pat == code[6:0]) return {1'b0, 4'(i)};
    end
    return 5'h1F;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_digit[i] = 4'h0;
      m_dp[i]    = 1'b0;
      m_seen[i]  = 1'b0;
      e_digit[i] = 4'h0;
    end
    m_ferr       = 1'b0;
    e_dp         = 4'h0;
    e_err        = 1'b0;
    e_fv         = 1'b0;
    cycles_since = 0;
    prev_p       = 16'hFFFF;
    run_len      = 0;
  endtask

  task automatic model_step(input logic [15:0] p);
    int         idx;
    logic [4:0] dec;
    e_fv = 1'b0;
    if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
      for (int i = 0; i < 4; i++) begin
        e_digit[i] = m_digit[i];
        e_dp[i]    = m_dp[i];
        m_seen[i]  = 1'b0;
      end
      e_err        = m_ferr;
      m_ferr       = 1'b0;
      e_fv         = 1'b1;
      cycles_since = 0;
    end else begin
      cycles_since++;
    end
    // A digit is taken once its pattern has been sampled SETTLE+1 times in a row
    // (first sample plus SETTLE_CYCLES unchanged comparisons).
    run_len = (p == prev_p) ? run_len + 1 : 1;
    prev_p  = p;
    idx = ref_slot(p[15:8]);
    if (idx >= 0 && run_len == TB_SETTLE + 1) begin
      dec          = ref_decode(p[6:0]);
      m_digit[idx] = dec[3:0];
      m_dp[idx]    = ~p[7];
      m_seen[idx]  = 1'b1;
      if (dec[4]) m_ferr = 1'b1;
    end
  endtask

  // ---------------- per-cycle driving and comparison ----------------
  task automatic compare_cycle();
    check("frame_valid", frame_valid, e_fv);
    check("stale", stale, (cycles_since >= TB_TIMEOUT) ? 1'b1 : 1'b0);
    check("display", {hours2, hours1, mins2, mins1, dp, seg_err},
          {e_digit[3], e_digit[2], e_digit[1], e_digit[0], e_dp, e_err});
    if (frame_valid) begin
      frames++;
      last_digits = {hours2, hours1, mins2, mins1};
      last_err    = seg_err;
      stale_at_fv = stale;
    end
  endtask

  task automatic tick(input logic [7:0] s, input logic [7:0] g);
    seg_drivers   = s;
    seven_segment = g;
    @(posedge clk);
    if (rst_n) model_step({s, g});
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic hold(input logic [7:0] s, input logic [7:0] g, input int n);
    for (int i = 0; i < n; i++) tick(s, g);
  endtask

  task automatic apply_reset();
    seg_drivers   = 8'hFF;
    seven_segment = 8'hFF;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      compare_cycle();
    end
    rst_n = 1'b1;
  endtask

  task automatic frame_1234();
    hold(8'hFE, 8'h99, 20);
    hold(8'hFD, 8'hB0, 20);
    hold(8'hFB, 8'hA4, 20);
    hold(8'hF7, 8'hF9, 20);
  endtask

  int f0;

  initial begin
    frames        = 0;
    last_digits   = '0;
    last_err      = 1'b0;
    stale_at_fv   = 1'b0;
    rst_n         = 1'b0;
    seg_drivers   = 8'hFF;
    seven_segment = 8'hFF;
    model_reset();
    @(negedge clk);
    apply_reset();
    check("reset_digits", {hours2, hours1, mins2, mins1, dp}, 20'h0);
    check("reset_flags", {frame_valid, seg_err, stale}, 3'b000);

    // Display 12:34.
    f0 = frames;
    frame_1234();
    check("t1_frames", frames - f0, 1);
    check("t1_digits", last_digits, 16'h1234);
    check("t1_err", last_err, 1'b0);

    // Settle glitch: the short 4 must never be captured.
    apply_reset();
    f0 = frames;
    hold(8'hFE, 8'h99, 10);
    hold(8'hFE, 8'h92, 20);
    hold(8'hFD, 8'hB0, 20);
    hold(8'hFB, 8'hA4, 20);
    hold(8'hF7, 8'hF9, 20);
    check("t2_frames", frames - f0, 1);
    check("t2_digits", last_digits, 16'h1235);

    // Undecodable pattern on hours1, then a clean frame.
    apply_reset();
    f0 = frames;
    hold(8'hFE, 8'h99, 20);
    hold(8'hFD, 8'hB0, 20);
    hold(8'hFB, 8'hFF, 20);
    hold(8'hF7, 8'hF9, 20);
    check("t3_digits", last_digits, 16'h1F34);
    check("t3_err", last_err, 1'b1);
    frame_1234();
    check("t3_frames", frames - f0, 2);
    check("t3_clean_err", last_err, 1'b0);

    // Blanking and illegal selects between digits.
    apply_reset();
    f0 = frames;
    hold(8'hFE, 8'h99, 20);
    hold(8'hFF, 8'hC0, 5);
    hold(8'hFD, 8'hB0, 20);
    hold(8'hFC, 8'hC0, 5);
    hold(8'hFB, 8'hA4, 20);
    hold(8'hFF, 8'hC0, 3);
    hold(8'hF7, 8'hF9, 20);
    check("t4_frames", frames - f0, 1);
    check("t4_digits", last_digits, 16'h1234);

    // Timeout, then recovery by a full frame.
    hold(8'hFF, 8'hFF, TB_TIMEOUT);
    check("t5_stale", stale, 1'b1);
    check("t5_hold_digits", {hours2, hours1, mins2, mins1}, 16'h1234);
    f0 = frames;
    hold(8'hFE, 8'h94, 20);
    hold(8'hFD, 8'hB0, 20);
    hold(8'hFB, 8'hA4, 20);
    hold(8'hF7, 8'hF9, 20);
    check("t5_frames", frames - f0, 1);
    check("t5_stale_at_fv", stale_at_fv, 1'b0);

    // Reset mid-frame discards partial slots.
    apply_reset();
    f0 = frames;
    hold(8'hFE, 8'h99, 20);
    hold(8'hFD, 8'hB0, 20);
    apply_reset();
    hold(8'hFB, 8'hA4, 20);
    hold(8'hF7, 8'hF9, 20);
    hold(8'hFE, 8'h99, 20);
    check("t6_no_frame", frames - f0, 0);
    check("t6_zero", {hours2, hours1, mins2, mins1, dp}, 20'h0);
    hold(8'hFD, 8'hB0, 20);
    check("t6_frames", frames - f0, 1);
    check("t6_digits", last_digits, 16'h1234);

    // Randomized scan traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      int         kind;
      int         n;
      logic [3:0] oh;
      logic [7:0] s;
      logic [7:0] g;
      kind = $urandom_range(0, 99);
      n    = $urandom_range(1, 30);
      oh   = 4'b0001 << $urandom_range(0, 3);
      g    = seg_table[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) == 1) g[7] = 1'b0;
      if (kind < 75) begin
        s = {4'hF, ~oh};
        if (kind >= 68) g = 8'($urandom);
      end else if (kind < 90) begin
        s = 8'hFF;
      end else begin
        s = 8'($urandom);
      end
      hold(s, g, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ss_scan_decoder.md
Name: ss_scan_decoder

Overview:
- Receive-side counterpart of the seven-segment scan driver.
- Samples the multiplexed SegmentDrivers/SevenSegment bus and reconstructs the four displayed BCD digits (hours2, hours1, mins2, mins1).
- Publishes each completed display frame with a one-cycle valid strobe.
- Used for on-chip display readback, self-check and the verification loopback; sits beside the wall clock on the same 100 MHz domain.

Parameters:
- SETTLE_CYCLES, 16: consecutive identical input cycles required before a digit is captured.
- TIMEOUT_CYCLES, 2097152: cycles without a completed frame before STALE asserts.

Ports:
- CLK100MHZ  input  1  system clock, all logic on rising edge.
- RESET_N  input  1  reset, asynchronous assert, active-low.
- SegmentDrivers  input  8  anode enables, active-low; bit0=mins1, bit1=mins2, bit2=hours1, bit3=hours2; bits 7:4 unused and must be high.
- SevenSegment  input  8  cathodes, active-low, {dp,g,f,e,d,c,b,a}.
- hours2  output  4  captured digit.
- hours1  output  4  captured digit.
- mins2  output  4  captured digit.
- mins1  output  4  captured digit.
- DP  output  4  captured decimal points, active-high, same bit order as anodes.
- FRAME_VALID  output  1  one-cycle strobe: outputs updated this cycle.
- SEG_ERR  output  1  frame contained an undecodable pattern; qualified by FRAME_VALID.
- STALE  output  1  level: no frame completed within TIMEOUT_CYCLES.

Behaviour:
- Inputs are same-domain; no synchronisers.
- Reset (RESET_N low, async): all digits 0, DP 0, FRAME_VALID 0, SEG_ERR 0, STALE 0, seen mask 0, state BLANK, counters 0.
- Pattern P = {SegmentDrivers, SevenSegment}, registered once per cycle; each cycle compares P with the previous registered P.
- Valid select: SegmentDrivers[7:4]==4'hF and exactly one of [3:0] low. Anything else is blanking.
- State machine:
  - BLANK: on valid select go to SETTLE and clear the stable counter.
  - SETTLE: each cycle P is unchanged, increment the counter. If P changes, return to SETTLE with the counter cleared, or to BLANK if the new select is invalid. When the counter reaches SETTLE_CYCLES-1 with P unchanged, capture and go to HOLD.
  - HOLD: no further capture. On any change of P, go to SETTLE or BLANK as above.
- Capture:
  - Decode SevenSegment[6:0] into the digit slot for the selected anode and store ~SevenSegment[7] in the DP slot.
  - Set the slot's seen bit.
  - Undecodable pattern: store 4'hF and set the frame error flag.
  - Recapture of an already-seen slot overwrites it; the latest value wins.
- Decode table (active-low hex): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, with dp bit masked. Anything else is an error.
- Frame completion:
  - On the edge after the seen mask becomes 4'hF: load the output digits and DP from the slots, drive SEG_ERR from the frame error flag, and pulse FRAME_VALID for exactly one cycle.
  - The same edge clears the seen mask and the frame error flag.
  - Outputs hold their values between frames.
- Latency: last stable digit cycle → capture edge → FRAME_VALID on the next edge.
- Capture coinciding with frame completion: the capture belongs to the next frame (mask cleared, then new bit set).
- Timeout:
  - Counter clears on each FRAME_VALID and saturates at TIMEOUT_CYCLES.
  - STALE=1 while saturated; it deasserts in the same cycle FRAME_VALID pulses.
- Reset mid-frame: partial slots are discarded; outputs return to reset values immediately.

Decomposition:
- Shared package (reused by the scan driver and its bench):
  - segment encodings SEG_0..SEG_9, SEG_BLANK=8'hFF
  - anode index constants
  - bit-order localparams
- One sub-module, seg7_to_bcd: combinational 7-bit pattern → {err, digit[3:0]}.

Test Plan:
- Display 12:34: drive FE/99, FD/B0, FB/A4, F7/F9 for 20 cycles each. Required: one FRAME_VALID; hours2=1, hours1=2, mins2=3, mins1=4; SEG_ERR=0.
- Settle glitch: FE/99 for 10 cycles, then FE/92 for 20 cycles, then the remaining digits as in the first test. Required: mins1=5, with no capture of 4.
- Invalid pattern: digit bit2 driven FB/FF during an otherwise valid frame. Required: hours1=F, SEG_ERR=1 with FRAME_VALID; the next clean frame has SEG_ERR=0.
- Blanking/illegal select: insert FF/C0 and FC/C0 between digits. Required: no capture or state change; the frame still completes correctly.
- Timeout: hold FF/FF for TIMEOUT_CYCLES cycles. Required: STALE=1, outputs unchanged. A subsequent full frame clears STALE in the same cycle as FRAME_VALID.
- Reset mid-frame: capture 2 digits, pulse RESET_N low, then drive 3 digits. Required: no FRAME_VALID, outputs 0. Completing the 4th digit yields FRAME_VALID.
